// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter and sequencer for sharing one UART transmitter among four requesters.
// A requester can hold the transmitter for a multi-byte burst, up to MAX_BURST bytes.
// The optional WAIT timeout is built only when ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int unsigned DBIT        = 8,
  parameter int unsigned MAX_BURST   = 16,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          req,
  input  logic [4*DBIT-1:0]   req_data,
  input  logic [3:0]          req_last,
  output logic [3:0]          gnt_ack,
  output logic                tx_start,
  output logic [DBIT-1:0]     tx_data,
  input  logic                tx_done_tick,
  output logic                busy,
  output logic [1:0]          cur_grant,
  output logic                timeout_err
);

  typedef enum logic [1:0] {StIdle, StStart, StWait} state_e;

  localparam int unsigned BurstW = 8;
  localparam int unsigned TmoW   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  state_e              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic [DBIT-1:0]     data_q, data_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic                lock_q, lock_d;
  logic [BurstW-1:0]   burst_cnt_q, burst_cnt_d;
  logic                tmo_err_q, tmo_err_d;
  logic                tmo_expired;

  logic [DBIT-1:0]     lanes [4];
  logic                pick_valid;
  logic [1:0]          pick_idx;
  logic [1:0]          cand;
  logic                cont_burst;

  // Unpack the requester byte lanes.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lanes[i] = req_data[DBIT*i +: DBIT];
    end
  end

  // Round-robin pick: scan downwards so the lowest offset from rr_ptr is the one kept.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = rr_ptr_q;
    cand       = '0;
    for (int i = 3; i >= 0; i--) begin
      cand = rr_ptr_q + 2'(i);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign cont_burst = lock_q && req[grant_q] && (burst_cnt_q < BurstW'(MAX_BURST));

`ifdef ARB_TIMEOUT_EN
  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_expired = (state_q == StWait) && (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1));

  // Timeout counter: cleared on the way into WAIT, counts every WAIT cycle.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == StStart) begin
      tmo_cnt_d = '0;
    end else if (state_q == StWait) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  // No timeout in this build; WAIT lasts until tx_done_tick.
  logic [TmoW-1:0] unused_tmo_limit;
  assign unused_tmo_limit = TmoW'(TIMEOUT_CYC - 1);
  assign tmo_expired      = 1'b0;
`endif

  // Next-state logic for the IDLE/START/WAIT sequencer.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    data_d      = data_q;
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    burst_cnt_d = burst_cnt_q;
    tmo_err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d     = pick_idx;
          data_d      = lanes[pick_idx];
          burst_cnt_d = BurstW'(1);
          lock_d      = ~req_last[pick_idx];
          state_d     = StStart;
        end
      end
      StStart: begin
        state_d = StWait;
      end
      StWait: begin
        // A done tick in the expiry cycle takes priority over the timeout.
        if (tx_done_tick) begin
          if (cont_burst) begin
            data_d      = lanes[grant_q];
            burst_cnt_d = burst_cnt_q + 1'b1;
            lock_d      = ~req_last[grant_q];
            state_d     = StStart;
          end else begin
            lock_d   = 1'b0;
            rr_ptr_d = grant_q + 2'd1;
            state_d  = StIdle;
          end
        end else if (tmo_expired) begin
          tmo_err_d = 1'b1;
          lock_d    = 1'b0;
          rr_ptr_d  = grant_q + 2'd1;
          state_d   = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      data_q      <= '0;
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      burst_cnt_q <= '0;
      tmo_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      data_q      <= data_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      burst_cnt_q <= burst_cnt_d;
      tmo_err_q   <= tmo_err_d;
    end
  end

  // Outputs decoded from registered state only.
  assign tx_start    = (state_q == StStart);
  assign gnt_ack     = tx_start ? (4'b0001 << grant_q) : 4'b0000;
  assign busy        = (state_q != StIdle);
  assign tx_data     = data_q;
  assign cur_grant   = grant_q;
  assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter (MAX_BURST=4, TIMEOUT_CYC=50).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = 4'b0;
  logic [31:0] req_data = 32'b0;
  logic [3:0]  req_last = 4'b0;
  logic        tx_done_tick = 1'b0;
  logic [3:0]  gnt_ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic [1:0]  cur_grant;
  logic        timeout_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .DBIT       (8),
    .MAX_BURST  (4),
    .TIMEOUT_CYC(50)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .req_last    (req_last),
    .gnt_ack     (gnt_ack),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_done_tick(tx_done_tick),
    .busy        (busy),
    .cur_grant   (cur_grant),
    .timeout_err (timeout_err)
  );

  task automatic set_lane(input int ch, input logic [7:0] b, input logic last);
    req_data[8*ch +: 8] = b;
    req_last[ch] = last;
  endtask

  // Returns on the falling edge where tx_start is seen (bounded).
  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (tx_start === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Waits dly cycles, then drives a one-cycle tx_done_tick.
  task automatic pulse_done(input int dly);
    repeat (dly) @(negedge clk);
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({gnt_ack, tx_start, tx_data, busy, cur_grant, timeout_err} !== 17'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {gnt_ack, tx_start, tx_data, busy, cur_grant, timeout_err});
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic;
    set_lane(2, 8'hA5, 1'b1);
    req = 4'b0100;
    @(negedge clk);
    total++;
    if (tx_start !== 1'b1) begin bad++; $display("FAIL basic_start: got %b want 1", tx_start); end
    total++;
    if (gnt_ack !== 4'b0100) begin bad++; $display("FAIL basic_ack: got %b want 0100", gnt_ack); end
    total++;
    if (tx_data !== 8'hA5) begin bad++; $display("FAIL basic_data: got %h want a5", tx_data); end
    total++;
    if (cur_grant !== 2'd2) begin bad++; $display("FAIL basic_grant: got %0d want 2", cur_grant); end
    req = 4'b0000;
    @(negedge clk);
    total++;
    if ({gnt_ack, tx_start, busy} !== 6'b000001) begin
      bad++;
      $display("FAIL basic_wait: got ack=%b start=%b busy=%b want 0000 0 1",
               gnt_ack, tx_start, busy);
    end
    pulse_done(3);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL basic_done_idle: got %b want 0", busy); end
  endtask

  // rr_ptr is 3 after serving ch2, so ch3 goes before ch1.
  task automatic test_rr_order;
    bit seen;
    set_lane(1, 8'h11, 1'b1);
    set_lane(3, 8'h33, 1'b1);
    req = 4'b1010;
    wait_start(seen);
    total++;
    if (!seen || cur_grant !== 2'd3 || tx_data !== 8'h33) begin
      bad++;
      $display("FAIL rr_first: got seen=%b g=%0d d=%h want 1 3 33", seen, cur_grant, tx_data);
    end
    req[3] = 1'b0;
    pulse_done(2);
    wait_start(seen);
    total++;
    if (!seen || cur_grant !== 2'd1 || tx_data !== 8'h11) begin
      bad++;
      $display("FAIL rr_second: got seen=%b g=%0d d=%h want 1 1 11", seen, cur_grant, tx_data);
    end
    req[1] = 1'b0;
    pulse_done(2);
  endtask

  task automatic test_round_robin;
    bit seen;
    int exp_g[5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_d[5] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h50};
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_lane(i, 8'h40 + 8'(i), 1'b1);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_start(seen);
      total++;
      if (!seen || cur_grant !== 2'(exp_g[k]) || tx_data !== exp_d[k]
          || gnt_ack !== (4'b0001 << exp_g[k])) begin
        bad++;
        $display("FAIL rr4_grant%0d: got seen=%b g=%0d d=%h ack=%b want g=%0d d=%h",
                 k, seen, cur_grant, tx_data, gnt_ack, exp_g[k], exp_d[k]);
      end
      set_lane(exp_g[k], 8'h50 + 8'(exp_g[k]), 1'b1);
      if (k == 4) req = 4'b0000;
      @(negedge clk);
      total++;
      if (gnt_ack !== 4'b0000) begin
        bad++;
        $display("FAIL rr4_ack_width%0d: got %b want 0000", k, gnt_ack);
      end
      pulse_done(9);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL rr4_idle_gap%0d: got %b want 0", k, busy); end
    end
  endtask

  task automatic test_burst;
    bit seen;
    set_lane(0, 8'hC0, 1'b1);
    set_lane(1, 8'hB1, 1'b0);
    req = 4'b0011;
    wait_start(seen);
    total++;
    if (!seen || cur_grant !== 2'd1 || tx_data !== 8'hB1) begin
      bad++;
      $display("FAIL burst_b1: got seen=%b g=%0d d=%h want 1 1 b1", seen, cur_grant, tx_data);
    end
    set_lane(1, 8'hB2, 1'b0);
    pulse_done(3);
    total++;
    if (tx_start !== 1'b1 || gnt_ack !== 4'b0010 || tx_data !== 8'hB2) begin
      bad++;
      $display("FAIL burst_b2: got start=%b ack=%b d=%h want 1 0010 b2", tx_start, gnt_ack, tx_data);
    end
    set_lane(1, 8'hB3, 1'b1);
    pulse_done(3);
    total++;
    if (tx_start !== 1'b1 || gnt_ack !== 4'b0010 || tx_data !== 8'hB3) begin
      bad++;
      $display("FAIL burst_b3: got start=%b ack=%b d=%h want 1 0010 b3", tx_start, gnt_ack, tx_data);
    end
    req[1] = 1'b0;
    pulse_done(3);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL burst_release: got %b want 0", busy); end
    wait_start(seen);
    total++;
    if (!seen || cur_grant !== 2'd0 || tx_data !== 8'hC0) begin
      bad++;
      $display("FAIL burst_then_ch0: got seen=%b g=%0d d=%h want 1 0 c0", seen, cur_grant, tx_data);
    end
    req[0] = 1'b0;
    pulse_done(3);
  endtask

  task automatic test_max_burst;
    bit seen;
    set_lane(0, 8'hD0, 1'b0);
    req = 4'b0001;
    wait_start(seen);
    total++;
    if (!seen || cur_grant !== 2'd0 || tx_data !== 8'hD0) begin
      bad++;
      $display("FAIL max_first: got seen=%b g=%0d d=%h want 1 0 d0", seen, cur_grant, tx_data);
    end
    set_lane(1, 8'hE1, 1'b1);
    req[1] = 1'b1;
    for (int k = 1; k < 4; k++) begin
      set_lane(0, 8'hD0 + 8'(k), 1'b0);
      pulse_done(3);
      total++;
      if (tx_start !== 1'b1 || cur_grant !== 2'd0 || tx_data !== 8'hD0 + 8'(k)) begin
        bad++;
        $display("FAIL max_byte%0d: got start=%b g=%0d d=%h want 1 0 %h",
                 k, tx_start, cur_grant, tx_data, 8'hD0 + 8'(k));
      end
    end
    set_lane(0, 8'hD4, 1'b0);
    pulse_done(3);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL max_forced_release: got %b want 0", busy); end
    wait_start(seen);
    total++;
    if (!seen || cur_grant !== 2'd1 || tx_data !== 8'hE1) begin
      bad++;
      $display("FAIL max_then_ch1: got seen=%b g=%0d d=%h want 1 1 e1", seen, cur_grant, tx_data);
    end
    req = 4'b0000;
    pulse_done(3);
  endtask

  task automatic test_reset_mid;
    bit seen;
    set_lane(2, 8'h77, 1'b1);
    req = 4'b0100;
    wait_start(seen);
    total++;
    if (!seen || cur_grant !== 2'd2) begin
      bad++;
      $display("FAIL rstmid_grant: got seen=%b g=%0d want 1 2", seen, cur_grant);
    end
    req = 4'b0000;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if ({gnt_ack, tx_start, tx_data, busy, cur_grant, timeout_err} !== 17'h0) begin
      bad++;
      $display("FAIL rstmid_async: got %h want 0",
               {gnt_ack, tx_start, tx_data, busy, cur_grant, timeout_err});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_lane(i, 8'h60 + 8'(i), 1'b1);
    req = 4'b1111;
    wait_start(seen);
    total++;
    if (!seen || cur_grant !== 2'd0 || tx_data !== 8'h60) begin
      bad++;
      $display("FAIL rstmid_first_ch0: got seen=%b g=%0d d=%h want 1 0 60", seen, cur_grant, tx_data);
    end
    req = 4'b0000;
    pulse_done(3);
  endtask

  task automatic test_timeout;
    bit seen;
    set_lane(0, 8'h0A, 1'b1);
    set_lane(2, 8'h2A, 1'b1);
    req = 4'b0101;
    wait_start(seen);
    total++;
    if (!seen || cur_grant !== 2'd2) begin
      bad++;
      $display("FAIL tmo_grant: got seen=%b g=%0d want 1 2", seen, cur_grant);
    end
    req[2] = 1'b0;
`ifdef ARB_TIMEOUT_EN
    begin
      int n = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        n++;
        if (timeout_err === 1'b1) break;
      end
      total++;
      if (n != 51 || busy !== 1'b0) begin
        bad++;
        $display("FAIL tmo_pulse_time: got cycles=%0d busy=%b want 51 0", n, busy);
      end
      @(negedge clk);
      total++;
      if (timeout_err !== 1'b0 || tx_start !== 1'b1 || cur_grant !== 2'd0) begin
        bad++;
        $display("FAIL tmo_next_grant: got err=%b start=%b g=%0d want 0 1 0",
                 timeout_err, tx_start, cur_grant);
      end
      req = 4'b0000;
      pulse_done(3);
    end
`else
    begin
      bit err_seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (timeout_err !== 1'b0) err_seen = 1'b1;
      end
      total++;
      if (err_seen || busy !== 1'b1) begin
        bad++;
        $display("FAIL notmo_hold: got err=%b busy=%b want 0 1", err_seen, busy);
      end
      pulse_done(1);
      wait_start(seen);
      total++;
      if (!seen || cur_grant !== 2'd0 || tx_data !== 8'h0A) begin
        bad++;
        $display("FAIL notmo_next: got seen=%b g=%0d d=%h want 1 0 0a", seen, cur_grant, tx_data);
      end
      req = 4'b0000;
      pulse_done(3);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rr_order();
    test_round_robin();
    test_burst();
    test_max_burst();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
